conv55_scan_ctrl: RTL and testbench
===================================

Name: conv55_scan_ctrl

Overview:
- Sequencer for the 5x5 sliding-window convolution unit: raster-scans an IMG_W x IMG_H feature map with stride 1, no padding.
- Each cycle it issues one 5-pixel column read: rows r..r+4 at column c.
- Drives the convolver's shift enable and flags which convolver outputs are valid window results, with their output coordinates.
- Sits between the feature-map buffer (5-wide column read port) and the convolver. Pixel data flows memory -> convolver directly, not through this block.

Parameters:
- IMG_W, 32, input map width in pixels; must be >= 5.
- IMG_H, 32, input map height in pixels; must be >= 5.
- COORD_W, 6, width of all row/column coordinate ports; must hold max(IMG_W, IMG_H) - 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- abort  in  1  synchronous abort; squashes the scan.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse after the final result.
- mem_rd_en  out  1  column read request; data returns the next cycle.
- mem_row  out  COORD_W  top row r of the 5-row column slice.
- mem_col  out  COORD_W  column c.
- conv_en  out  1  convolver shift enable; high in the cycle read data is present.
- out_valid  out  1  convolver output holds a complete window result.
- out_row  out  COORD_W  output row of the current result.
- out_col  out  COORD_W  output column of the current result.
- out_last  out  1  qualifies the final result (with out_valid).

Behaviour:
- Reset (async assert, rst_n low): state IDLE, all outputs 0, counters r=c=0, pipeline flags cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN; r=0, c=0.
  - RUN: mem_rd_en=1 every cycle; mem_row=r, mem_col=c (registered outputs).
    - c increments each cycle.
    - At c=IMG_W-1: c wraps to 0 and r increments.
    - If r=IMG_H-5 at that point -> DRAIN instead.
  - DRAIN: mem_rd_en=0; wait until both pipeline stages are empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy: high from the first RUN cycle through the DONE cycle inclusive.
- Pipeline stage 1: conv_en is mem_rd_en delayed 1 cycle. The column counter is delayed alongside as c1.
- Pipeline stage 2: out_valid is registered as conv_en AND (c1 >= 4).
  - out_row = row of the read.
  - out_col = c1 - 4.
  - out_last = that read was (IMG_H-5, IMG_W-1).
- Latency: result for window (r, j) has out_valid exactly 2 cycles after the read of column j+4.
- Timing with the start edge as cycle 0:
  - First read in cycle 1.
  - First out_valid in cycle 7.
  - Last out_valid in cycle (IMG_H-4)*IMG_W + 2; done the cycle after.
- Row refill: each row has IMG_W-4 consecutive valid results, then a 4-cycle gap while the window refills across the row boundary. The window must never mix rows in a flagged result.
- Results total (IMG_H-4)*(IMG_W-4); no backpressure. The downstream consumer accepts every out_valid.
- start while not IDLE: ignored, including in the DONE cycle.
- abort=1 in RUN or DRAIN:
  - Next cycle: IDLE.
  - mem_rd_en, conv_en, out_valid forced 0 from the next cycle; in-flight flags squashed.
  - No done pulse; busy drops.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, stay IDLE.
- rst_n asserted mid-scan: immediate return to reset values; no done.
- Coordinates are unsigned.
- All counter compares are exact equality at terminal values, so no overflow occurs when IMG_W or IMG_H is 2**COORD_W - 1.

Test Plan:
- IMG_W=8, IMG_H=6, pulse start at cycle 0:
  - Reads in cycles 1-16.
  - out_valid in cycles 7-10 (row 0, cols 0-3) and 15-18 (row 1, cols 0-3).
  - out_last only in cycle 18; done in cycle 19; busy cycles 1-19.
- Same config, convolver fed with known column data (pixel = row*8+col, all-ones filter): out_valid windows match the golden 5x5 sums. conv_en is never high without the preceding mem_rd_en.
- Minimum map IMG_W=5, IMG_H=5: reads cycles 1-5, single out_valid in cycle 7 with out_row=0, out_col=0, out_last=1; done in cycle 8.
- Defaults 32x32: 784 out_valid pulses; last in cycle 898; done in cycle 899; gap of exactly 4 cycles between rows.
- abort in cycle 9 of the 8x6 scan: all outputs quiet from cycle 10, no done. A fresh start then reproduces scenario 1 timing exactly.
- start held high through DONE, and start pulsed mid-RUN: no second scan and no timing change. rst_n low mid-RUN: outputs 0 asynchronously.

Source files
------------

// File: rtl/conv55_scan_ctrl_if.sv
// Handshake and control bundle between the 5x5 scan sequencer, the feature-map
// column read port and the convolver.
interface conv55_scan_ctrl_if #(
  parameter int COORD_W = 6
);
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               mem_rd_en;
  logic [COORD_W-1:0] mem_row;
  logic [COORD_W-1:0] mem_col;
  logic               conv_en;
  logic               out_valid;
  logic [COORD_W-1:0] out_row;
  logic [COORD_W-1:0] out_col;
  logic               out_last;

  modport master (
    input  start, abort,
    output busy, done, mem_rd_en, mem_row, mem_col,
           conv_en, out_valid, out_row, out_col, out_last
  );

  modport slave (
    output start, abort,
    input  busy, done, mem_rd_en, mem_row, mem_col,
           conv_en, out_valid, out_row, out_col, out_last
  );
endinterface

// File: rtl/conv55_scan_ctrl.sv
// Raster-scan sequencer for the 5x5 stride-1 convolver: issues one 5-row column
// read per cycle and flags which convolver outputs are complete windows.
module conv55_scan_ctrl #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int COORD_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv55_scan_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 5);
  localparam logic [COORD_W-1:0] WIN_SPAN = COORD_W'(4);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  state_t             state;
  logic [COORD_W-1:0] c1;
  logic [COORD_W-1:0] r1;
  logic               last1;
  logic               win_full;

  // A window is complete only once five columns of the same row have shifted in,
  // which also keeps the row-boundary refill from producing mixed-row results.
  assign win_full = bus.conv_en && (c1 >= WIN_SPAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_row   <= '0;
      bus.mem_col   <= '0;
      bus.conv_en   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.out_last  <= 1'b0;
      c1            <= '0;
      r1            <= '0;
      last1         <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.conv_en   <= bus.mem_rd_en;
      c1            <= bus.mem_col;
      r1            <= bus.mem_row;
      last1         <= (bus.mem_row == ROW_LAST) && (bus.mem_col == COL_LAST);
      bus.out_valid <= win_full;
      bus.out_last  <= win_full && last1;
      if (win_full) begin
        bus.out_row <= r1;
        bus.out_col <= c1 - WIN_SPAN;
      end

      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state         <= RUN;
            bus.busy      <= 1'b1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_row   <= '0;
            bus.mem_col   <= '0;
          end
        end

        RUN: begin
          if (bus.abort) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.conv_en   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
          end else if (bus.mem_col == COL_LAST) begin
            bus.mem_col <= '0;
            if (bus.mem_row == ROW_LAST) begin
              state         <= DRAIN;
              bus.mem_rd_en <= 1'b0;
            end else begin
              bus.mem_row <= bus.mem_row + ONE;
            end
          end else begin
            bus.mem_col <= bus.mem_col + ONE;
          end
        end

        // Leave once nothing new can enter stage 2: with conv_en low now, both
        // stages are empty after this edge, so done lands right after the last result.
        DRAIN: begin
          if (bus.abort) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.conv_en   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
          end else if (!bus.conv_en) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv55_scan_ctrl.sv
// Randomized directed bench for conv55_scan_ctrl: three map sizes, a cycle-indexed
// timing model of the scan, and a column-fed convolver checked against 5x5 sums.
module tb_conv55_scan_ctrl;

  logic clk;
  logic rst_n;
  int   sel;
  logic start_drv;
  logic abort_drv;
  int   checks;
  int   errors;

  conv55_scan_ctrl_if #(.COORD_W(6)) bus0 ();
  conv55_scan_ctrl_if #(.COORD_W(6)) bus1 ();
  conv55_scan_ctrl_if #(.COORD_W(6)) bus2 ();

  conv55_scan_ctrl #(.IMG_W(8),  .IMG_H(6),  .COORD_W(6)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  conv55_scan_ctrl #(.IMG_W(5),  .IMG_H(5),  .COORD_W(6)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
  conv55_scan_ctrl #(.IMG_W(32), .IMG_H(32), .COORD_W(6)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

  assign bus0.start = start_drv && (sel == 0);
  assign bus0.abort = abort_drv && (sel == 0);
  assign bus1.start = start_drv && (sel == 1);
  assign bus1.abort = abort_drv && (sel == 1);
  assign bus2.start = start_drv && (sel == 2);
  assign bus2.abort = abort_drv && (sel == 2);

  logic       busy, done, rd_en, conv_en, out_valid, out_last;
  logic [5:0] mem_row, mem_col, out_row, out_col;
  int         cur_w;

  always_comb begin
    busy = bus0.busy; done = bus0.done; rd_en = bus0.mem_rd_en; conv_en = bus0.conv_en;
    out_valid = bus0.out_valid; out_last = bus0.out_last; mem_row = bus0.mem_row;
    mem_col = bus0.mem_col; out_row = bus0.out_row; out_col = bus0.out_col; cur_w = 8;
    if (sel == 1) begin
      busy = bus1.busy; done = bus1.done; rd_en = bus1.mem_rd_en; conv_en = bus1.conv_en;
      out_valid = bus1.out_valid; out_last = bus1.out_last; mem_row = bus1.mem_row;
      mem_col = bus1.mem_col; out_row = bus1.out_row; out_col = bus1.out_col; cur_w = 5;
    end else if (sel == 2) begin
      busy = bus2.busy; done = bus2.done; rd_en = bus2.mem_rd_en; conv_en = bus2.conv_en;
      out_valid = bus2.out_valid; out_last = bus2.out_last; mem_row = bus2.mem_row;
      mem_col = bus2.mem_col; out_row = bus2.out_row; out_col = bus2.out_col; cur_w = 32;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pixel(row, col) = row*W + col; a column read returns the sum of its five pixels
  function automatic int colSum(input int w, input int r, input int c);
    int s = 0;
    for (int i = 0; i < 5; i++) s += (r + i) * w + c;
    return s;
  endfunction

  function automatic int goldSum(input int w, input int r, input int c);
    int s = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) s += (r + i) * w + (c + j);
    return s;
  endfunction

  // Feature-map read port (one cycle latency) and an all-ones 5x5 convolver
  int   rdata;
  int   win [5];
  logic prev_rd;

  always @(posedge clk) begin
    prev_rd <= rd_en;
    if (rd_en) rdata <= colSum(cur_w, int'(mem_row), int'(mem_col));
    if (conv_en) begin
      for (int i = 0; i < 4; i++) win[i] <= win[i + 1];
      win[4] <= rdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start_drv = s;
    abort_drv = a;
  endtask

  // One scan with start sampled at the end of cycle 0. noise: 0 none,
  // 1 random start pulses while busy, 2 start held through the DONE cycle.
  task automatic runScan(input int w, input int h, input int abort_at, input int noise);
    int  reads    = (h - 4) * w;
    int  done_at  = reads + 3;
    int  end_at   = done_at + 3;
    int  stop_at  = (abort_at > 0) ? abort_at : done_at;
    int  nvalid   = 0;
    int  k;
    bit  alive, exp_rd, exp_valid, s;
    for (int n = 0; n <= end_at; n++) begin
      @(negedge clk);
      alive  = (abort_at <= 0) || (n <= abort_at);
      exp_rd = alive && (n >= 1) && (n <= reads);
      checkOutput("busy", busy, alive && n >= 1 && n <= done_at);
      checkOutput("done", done, alive && n == done_at);
      checkOutput("mem_rd_en", rd_en, exp_rd);
      checkOutput("conv_en", conv_en, alive && n >= 2 && n <= reads + 1);
      if (conv_en) checkOutput("conv_en_after_read", prev_rd, 1'b1);
      if (exp_rd) begin
        checkOutput("mem_row", mem_row, (n - 1) / w);
        checkOutput("mem_col", mem_col, (n - 1) % w);
      end
      k = n - 3;
      exp_valid = alive && k >= 0 && k < reads && (k % w) >= 4;
      checkOutput("out_valid", out_valid, exp_valid);
      checkOutput("out_last", out_last, exp_valid && k == reads - 1);
      if (exp_valid) begin
        nvalid++;
        checkOutput("out_row", out_row, k / w);
        checkOutput("out_col", out_col, (k % w) - 4);
        checkOutput("window_sum", win[0] + win[1] + win[2] + win[3] + win[4],
                    goldSum(w, k / w, (k % w) - 4));
      end
      s = (n == 0) ||
          (noise == 1 && n <= stop_at && $urandom_range(0, 1) == 1) ||
          (noise == 2 && n <= stop_at);
      applyStimulus(s, n == abort_at);
    end
    applyStimulus(1'b0, 1'b0);
    if (abort_at <= 0) checkOutput("valid_count", nvalid, (h - 4) * (w - 4));
  endtask

  initial begin
    int a;
    checks = 0;
    errors = 0;
    sel    = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rd_en", rd_en, 1'b0);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_mem_col", mem_col, 6'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 8x6 nominal, abort at 9, restart, start noise");
    runScan(8, 6, -1, 0);
    runScan(8, 6, 9, 0);
    runScan(8, 6, -1, 0);
    runScan(8, 6, -1, 2);
    runScan(8, 6, -1, 1);
    a = $urandom_range(1, 18);
    runScan(8, 6, a, 1);
    runScan(8, 6, -1, 0);

    $display("[TB] abort and start together in IDLE");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_abort_busy", busy, 1'b0);
      checkOutput("idle_abort_rd_en", rd_en, 1'b0);
    end

    $display("[TB] reset asserted mid-scan");
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", busy, 1'b0);
    checkOutput("async_reset_rd_en", rd_en, 1'b0);
    checkOutput("async_reset_conv_en", conv_en, 1'b0);
    checkOutput("async_reset_out_valid", out_valid, 1'b0);
    checkOutput("async_reset_out_row", out_row, 6'd0);
    checkOutput("async_reset_mem_row", mem_row, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runScan(8, 6, -1, 0);

    $display("[TB] 5x5 minimum map");
    sel = 1;
    runScan(5, 5, -1, 0);
    a = $urandom_range(1, 7);
    runScan(5, 5, a, 1);
    runScan(5, 5, -1, 1);

    $display("[TB] 32x32 default map");
    sel = 2;
    runScan(32, 32, -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
